// File: rtl/pmod_i2s_pkg.sv
// pmod_i2s_pkg: state encodings and counter-width helpers for the Pmod I2S frame controller
package pmod_i2s_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, GAP = 2'b10} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int v);
    return clog2(v) > 0 ? clog2(v) : 1;
  endfunction
endpackage

// File: rtl/pmod_piso_shifter.sv
// pmod_piso_shifter: parallel-load, left-shifting register presenting its MSB, clocked on the falling edge
module pmod_piso_shifter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] q;
  always_ff @(negedge clk)
    if (!rst_n) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[W-2:0], 1'b0};
  assign msb = q[W-1];
endmodule

// File: rtl/pmod_i2s_frame_ctrl.sv
// pmod_i2s_frame_ctrl: Pmod DAC serial frame controller; define PMOD_I2S_REPEAT_EN to replay the last sample on underrun
module pmod_i2s_frame_ctrl import pmod_i2s_pkg::*; #(
  parameter int DATA_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int GAP_CYC = 2
) (
  input  logic                       clk_sclk,
  input  logic                       rst_n,
  input  logic                       i2s_en,
  input  logic                       s_valid,
  input  logic [DATA_W*NUM_CH-1:0]   s_data,
  output logic                       s_ready,
  output logic                       cntr_ncs,
  output logic                       cntr_load,
  output logic                       sdata,
  output logic [cnt_w(NUM_CH)-1:0]   ch_idx,
  output logic                       frame_done,
  output logic                       underrun
);
  localparam int TOT = DATA_W * NUM_CH;
  localparam int BW  = cnt_w(DATA_W);
  localparam int CW  = cnt_w(NUM_CH);
  localparam int GW  = cnt_w(GAP_CYC);
  state_t state, next;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] ch_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TOT-1:0] load_data;
  logic start, reload, last, msb;
  assign s_ready = rst_n && i2s_en && state == IDLE;
  assign last = state == SHIFT && bit_cnt == '0 && ch_cnt == CW'(NUM_CH - 1);
`ifdef PMOD_I2S_REPEAT_EN
  logic [TOT-1:0] last_s;
  assign reload = s_ready && !s_valid;
  assign load_data = s_valid ? s_data : last_s;
  always_ff @(negedge clk_sclk)
    if (!rst_n) begin
      last_s <= '0;
      underrun <= 1'b0;
    end else begin
      if (s_ready && s_valid) last_s <= s_data;
      underrun <= reload;
    end
`else
  assign reload = 1'b0;
  assign load_data = s_data;
  assign underrun = 1'b0;
`endif
  assign start = (s_ready && s_valid) || reload;
  // the unused 2'b11 encoding falls back to IDLE
  always_comb
    next = state == IDLE  ? (start ? SHIFT : IDLE) :
           state == SHIFT ? (last ? GAP : SHIFT) :
           state == GAP   ? (gap_cnt == '0 ? IDLE : GAP) : IDLE;
  always_ff @(negedge clk_sclk)
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      ch_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= next;
      if (start) begin
        bit_cnt <= BW'(DATA_W - 1);
        ch_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt == '0 ? BW'(DATA_W - 1) : bit_cnt - 1'b1;
        ch_cnt <= last ? '0 : bit_cnt == '0 ? ch_cnt + 1'b1 : ch_cnt;
      end
      gap_cnt <= last ? GW'(GAP_CYC - 1) : state == GAP ? gap_cnt - 1'b1 : gap_cnt;
    end
  pmod_piso_shifter #(.W(TOT)) u_shift (
    .clk(clk_sclk),
    .rst_n(rst_n),
    .load(start),
    .shift(state == SHIFT),
    .din(load_data),
    .msb(msb)
  );
  assign cntr_ncs = state != SHIFT;
  assign cntr_load = state == IDLE;
  assign sdata = state == SHIFT && msb;
  assign ch_idx = state == SHIFT ? ch_cnt : '0;
  assign frame_done = last;
endmodule

// File: tb/tb_pmod_i2s_frame_ctrl.sv
// tb_pmod_i2s_frame_ctrl: randomized and directed checks against a frame-position reference model
module tb_pmod_i2s_frame_ctrl;
  localparam int DW = 16, NC = 2, GC = 2, TOT = DW * NC, PER = 1 + TOT + GC;
  logic clk_sclk = 1'b1, rst_n = 1'b0, i2s_en = 1'b0, s_valid = 1'b0, s_valid8 = 1'b0;
  logic [TOT-1:0] s_data = '0;
  logic [7:0] s_data8 = 8'h00;
  logic s_ready, cntr_ncs, cntr_load, sdata, frame_done, underrun;
  logic s_ready8, ncs8, load8, sdata8, done8, urun8;
  logic [0:0] ch_idx, ch8;
  int n_chk = 0, n_err = 0, cyc = 0, t = 0, n_low = 0, n_urun = 0, low8 = 0, nz8 = 0;
  bit busy = 0, urun = 0, sh;
  logic [TOT-1:0] word = '0, last_s = '0, cap = '0;
  logic [7:0] cap8 = '0;
  int hs_q[$];

  pmod_i2s_frame_ctrl #(.DATA_W(DW), .NUM_CH(NC), .GAP_CYC(GC)) dut (
    .clk_sclk(clk_sclk), .rst_n(rst_n), .i2s_en(i2s_en), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .cntr_ncs(cntr_ncs), .cntr_load(cntr_load), .sdata(sdata),
    .ch_idx(ch_idx), .frame_done(frame_done), .underrun(underrun));

  pmod_i2s_frame_ctrl #(.DATA_W(8), .NUM_CH(1), .GAP_CYC(GC)) dut8 (
    .clk_sclk(clk_sclk), .rst_n(rst_n), .i2s_en(i2s_en), .s_valid(s_valid8), .s_data(s_data8),
    .s_ready(s_ready8), .cntr_ncs(ncs8), .cntr_load(load8), .sdata(sdata8),
    .ch_idx(ch8), .frame_done(done8), .underrun(urun8));

  always #5 clk_sclk = ~clk_sclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: t is the cycle position inside the current frame (shift bits then gap)
  task automatic tick();
    cyc++;
    if (!rst_n) begin
      busy = 0;
      urun = 0;
      last_s = '0;
    end else if (!busy) begin
      urun = 0;
      if (i2s_en && s_valid) begin
        busy = 1; t = 0; word = s_data; last_s = s_data;
        hs_q.push_back(cyc);
      end
`ifdef PMOD_I2S_REPEAT_EN
      else if (i2s_en) begin
        busy = 1; t = 0; word = last_s; urun = 1;
      end
`endif
    end else begin
      t++;
      urun = 0;
      if (t == TOT + GC) busy = 0;
    end
    @(posedge clk_sclk);
    sh = busy && t < TOT;
    chk("ncs", 32'(cntr_ncs), 32'(!sh));
    chk("load", 32'(cntr_load), 32'(!busy));
    chk("sdata", 32'(sdata), 32'(sh ? word[TOT-1-t] : 1'b0));
    chk("ch_idx", 32'(ch_idx), sh ? 32'(t / DW) : 32'd0);
    chk("frame_done", 32'(frame_done), 32'(sh && t == TOT - 1));
    chk("s_ready", 32'(s_ready), 32'(!busy && i2s_en && rst_n));
    chk("underrun", 32'(underrun), 32'(urun));
    if (!cntr_ncs) begin cap = {cap[TOT-2:0], sdata}; n_low++; end
    if (underrun) n_urun++;
    if (!ncs8) begin cap8 = {cap8[6:0], sdata8}; low8++; end
    if (ch8 != 1'b0) nz8++;
  endtask

  initial begin
    logic [TOT-1:0] d;
    repeat (3) tick();
    rst_n = 1;
    tick();
    // single frame
    i2s_en = 1; s_valid = 1; s_data = 32'hA5A5_0F0F; cap = '0; n_low = 0;
    tick();
    s_valid = 0; i2s_en = 0;
    repeat (TOT + GC + 3) tick();
    chk("t1_bits", cap, 32'hA5A5_0F0F);
    chk("t1_low", n_low, TOT);
    // back-to-back
    hs_q.delete();
    i2s_en = 1; s_valid = 1; s_data = $urandom;
    for (int i = 0; i < 200 && hs_q.size() < 3; i++) begin
      int n = hs_q.size();
      tick();
      if (hs_q.size() != n) s_data = $urandom;
    end
    s_valid = 0; i2s_en = 0;
    chk("t2_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      chk("t2_gap0", hs_q[1] - hs_q[0], PER);
      chk("t2_gap1", hs_q[2] - hs_q[1], PER);
    end
    repeat (PER) tick();
    // reset at bit 10, then a fresh frame
    i2s_en = 1; s_valid = 1; s_data = $urandom;
    tick();
    s_valid = 0; i2s_en = 0;
    repeat (10) tick();
    rst_n = 0;
    tick();
    chk("t3_ncs", 32'(cntr_ncs), 1);
    chk("t3_sdata", 32'(sdata), 0);
    rst_n = 1;
    d = $urandom;
    i2s_en = 1; s_valid = 1; s_data = d; cap = '0; n_low = 0;
    tick();
    s_valid = 0; i2s_en = 0;
    repeat (TOT + GC) tick();
    chk("t3_bits", cap, d);
    // enable dropped at bit 5; s_valid alone must not be accepted
    d = $urandom;
    i2s_en = 1; s_valid = 1; s_data = d; cap = '0; n_low = 0;
    tick();
    s_valid = 0;
    repeat (5) tick();
    i2s_en = 0; s_valid = 1;
    repeat (TOT + GC + 20) tick();
    s_valid = 0;
    chk("t4_bits", cap, d);
    chk("t4_low", n_low, TOT);
    chk("t4_load", 32'(cntr_load), 1);
    // underrun behaviour
    i2s_en = 1; s_valid = 1; s_data = 32'h1234_5678; cap = '0; n_low = 0; n_urun = 0;
    tick();
    s_valid = 0;
    repeat (2 * TOT + GC) tick();
    chk("t5_bits", cap, 32'h1234_5678);
`ifdef PMOD_I2S_REPEAT_EN
    chk("t5_urun", n_urun, 1);
    chk("t5_low", n_low, 2 * TOT);
`else
    chk("t5_urun", n_urun, 0);
    chk("t5_low", n_low, TOT);
`endif
    i2s_en = 0;
    repeat (PER) tick();
    // random traffic
    repeat (3000) begin
      rst_n = $urandom_range(0, 199) != 0;
      i2s_en = $urandom_range(0, 9) != 0;
      s_valid = $urandom_range(0, 2) != 0;
      s_data = $urandom;
      tick();
    end
    // single 8-bit channel
    rst_n = 0; i2s_en = 0; s_valid = 0;
    tick();
    rst_n = 1;
    tick();
    i2s_en = 1; s_valid8 = 1; s_data8 = 8'h81; cap8 = '0; low8 = 0; nz8 = 0;
    tick();
    s_valid8 = 0; i2s_en = 0;
    repeat (12) tick();
    chk("t6_bits", 32'(cap8), 32'h81);
    chk("t6_low", low8, 8);
    chk("t6_ch", nz8, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
